// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command engine: FSM states, reply kinds,
// the ASCII characters of the command grammar and the fixed reply strings.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_COLON,
    ST_ADDR,
    ST_EQ,
    ST_DATA,
    ST_CLOSE,
    ST_SPI_START,
    ST_SPI_WAIT,
    ST_TX
  } state_e;

  typedef enum logic [1:0] {
    RPL_OK,
    RPL_ERR,
    RPL_READ
  } reply_e;

  localparam logic [7:0] ASC_LBRACE = 8'h7B;
  localparam logic [7:0] ASC_RBRACE = 8'h7D;
  localparam logic [7:0] ASC_COLON  = 8'h3A;
  localparam logic [7:0] ASC_EQ     = 8'h3D;
  localparam logic [7:0] ASC_W      = 8'h57;
  localparam logic [7:0] ASC_R      = 8'h52;
  localparam logic [7:0] ASC_LF     = 8'h0A;
  localparam logic [7:0] ASC_O      = 8'h4F;
  localparam logic [7:0] ASC_K      = 8'h4B;
  localparam logic [7:0] ASC_E      = 8'h45;

  // Characters of the fixed replies "OK\n" and "ERR\n"
  function automatic logic [7:0] reply_char(input reply_e kind, input logic [1:0] idx);
    logic [7:0] c;
    c = ASC_LF;
    if (kind == RPL_OK) begin
      case (idx)
        2'd0:    c = ASC_O;
        2'd1:    c = ASC_K;
        default: c = ASC_LF;
      endcase
    end else begin
      case (idx)
        2'd0:    c = ASC_E;
        2'd1:    c = ASC_R;
        2'd2:    c = ASC_R;
        default: c = ASC_LF;
      endcase
    end
    return c;
  endfunction

  function automatic logic [6:0] led_code(input state_e s);
    logic [6:0] c;
    c = 7'b000_0000;
    case (s)
      ST_CMD:       c = 7'b000_0001;
      ST_COLON:     c = 7'b000_0010;
      ST_ADDR:      c = 7'b000_0100;
      ST_EQ:        c = 7'b000_1000;
      ST_DATA:      c = 7'b001_0000;
      ST_CLOSE:     c = 7'b010_0000;
      ST_SPI_START: c = 7'b100_0001;
      ST_SPI_WAIT:  c = 7'b100_0010;
      ST_TX:        c = 7'b100_0100;
      default:      c = 7'b000_0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_hex_codec.sv
// Combinational ASCII <-> nibble conversion. Decode accepts 0-9, A-F, a-f
// and flags anything else; encode always produces uppercase.
module uart_hex_codec (
  input  logic [7:0] asc_i,
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o,
  output logic       is_hex_o,
  output logic [7:0] asc_o
);

  logic [7:0] diff;

  always_comb begin
    nib_o    = 4'h0;
    is_hex_o = 1'b0;
    diff     = 8'h00;
    if (asc_i >= 8'h30 && asc_i <= 8'h39) begin
      diff     = asc_i - 8'h30;
      is_hex_o = 1'b1;
    end else if (asc_i >= 8'h41 && asc_i <= 8'h46) begin
      diff     = asc_i - 8'h37;
      is_hex_o = 1'b1;
    end else if (asc_i >= 8'h61 && asc_i <= 8'h66) begin
      diff     = asc_i - 8'h57;
      is_hex_o = 1'b1;
    end
    nib_o = diff[3:0];
  end

  always_comb begin
    if (nib_i < 4'd10) asc_o = 8'h30 + {4'h0, nib_i};
    else               asc_o = 8'h37 + {4'h0, nib_i};
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART-to-SPI register command engine: parses "{W:aa=ddddd}" / "{R:aa}",
// runs one SPI transaction and answers with "OK\n", read data or "ERR\n".
//
// state        | meaning
// IDLE         | waiting for '{'
// CMD          | expecting 'W' or 'R'
// COLON        | expecting ':'
// ADDR         | collecting address hex digits
// EQ           | expecting '=' (write only)
// DATA         | collecting data hex digits
// CLOSE        | expecting '}'
// SPI_START    | one-cycle SPI start pulse
// SPI_WAIT     | waiting for SPI completion (timed)
// TX           | sending reply bytes to uart_tx
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned SPI_ADDR_WIDTH  = 6,
  parameter int unsigned SPI_DATA_WIDTH  = 20,
  parameter int unsigned UART_DATA_WIDTH = 8,
  parameter int unsigned RX_TIMEOUT      = 1000000,
  parameter int unsigned SPI_TIMEOUT     = 4096
) (
  input  logic                       i_clk_sys,
  input  logic                       i_rst_n,
  input  logic [UART_DATA_WIDTH-1:0] i_uart_data,
  input  logic                       i_rx_done,
  input  logic                       i_uart_idle,
  output logic [UART_DATA_WIDTH-1:0] o_data_tx,
  output logic                       o_data_valid,
  output logic                       o_spi_start,
  output logic                       o_spi_rw,
  output logic [SPI_ADDR_WIDTH-1:0]  o_spi_addr,
  output logic [SPI_DATA_WIDTH-1:0]  o_spi_wdata,
  input  logic                       i_spi_done,
  input  logic [SPI_DATA_WIDTH-1:0]  i_spi_rdata,
  output logic                       o_busy,
  output logic [6:0]                 o_ld_debug
);

  localparam int unsigned ADDR_DIGITS = (SPI_ADDR_WIDTH + 3) / 4;
  localparam int unsigned DATA_DIGITS = (SPI_DATA_WIDTH + 3) / 4;
  localparam int unsigned RD_W        = DATA_DIGITS * 4;
  localparam logic [7:0]  ADDR_LAST   = 8'(ADDR_DIGITS - 1);
  localparam logic [7:0]  DATA_LAST   = 8'(DATA_DIGITS - 1);
  localparam logic [7:0]  RD_LAST     = 8'(DATA_DIGITS);
  localparam logic [31:0] RX_LOAD     = 32'(RX_TIMEOUT);
  localparam logic [31:0] SPI_LOAD    = 32'(SPI_TIMEOUT);

  state_e                      state_q, state_d;
  reply_e                      reply_q, reply_d;
  logic                        is_read_q, is_read_d;
  logic [SPI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [SPI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]                  dig_q, dig_d;
  logic [31:0]                 rx_cnt_q, rx_cnt_d;
  logic [31:0]                 spi_cnt_q, spi_cnt_d;
  logic [7:0]                  tx_idx_q, tx_idx_d;
  logic                        tx_wait_q, tx_wait_d;
  logic [RD_W-1:0]             rd_sh_q, rd_sh_d;
  logic [UART_DATA_WIDTH-1:0]  data_tx_q, data_tx_d;
  logic                        data_valid_q, data_valid_d;

  logic [7:0] rx_asc;
  logic [3:0] rx_nib;
  logic       rx_is_hex;
  logic [7:0] tx_hex_asc;
  logic [7:0] tx_char;
  logic [7:0] tx_last;
  logic       err;
  logic       restart;
  logic [7:0] rx_asc_unused;
  logic [3:0] tx_nib_unused;
  logic       tx_is_hex_unused;

  assign rx_asc = 8'(i_uart_data);

  uart_hex_codec u_rx_codec (
    .asc_i    (rx_asc),
    .nib_i    (4'h0),
    .nib_o    (rx_nib),
    .is_hex_o (rx_is_hex),
    .asc_o    (rx_asc_unused)
  );

  uart_hex_codec u_tx_codec (
    .asc_i    (8'h00),
    .nib_i    (rd_sh_q[RD_W-1 -: 4]),
    .nib_o    (tx_nib_unused),
    .is_hex_o (tx_is_hex_unused),
    .asc_o    (tx_hex_asc)
  );

  always_comb begin
    tx_char = ASC_LF;
    tx_last = 8'd3;
    case (reply_q)
      RPL_READ: begin
        tx_last = RD_LAST;
        if (tx_idx_q != RD_LAST) tx_char = tx_hex_asc;
      end
      RPL_OK: begin
        tx_last = 8'd2;
        tx_char = reply_char(RPL_OK, tx_idx_q[1:0]);
      end
      default: begin
        tx_last = 8'd3;
        tx_char = reply_char(RPL_ERR, tx_idx_q[1:0]);
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    reply_d      = reply_q;
    is_read_d    = is_read_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dig_d        = dig_q;
    rx_cnt_d     = rx_cnt_q;
    spi_cnt_d    = spi_cnt_q;
    tx_idx_d     = tx_idx_q;
    tx_wait_d    = tx_wait_q;
    rd_sh_d      = rd_sh_q;
    data_tx_d    = data_tx_q;
    data_valid_d = 1'b0;
    err          = 1'b0;
    restart      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done && rx_asc == ASC_LBRACE) restart = 1'b1;
      end
      ST_CMD, ST_COLON, ST_ADDR, ST_EQ, ST_DATA, ST_CLOSE: begin
        // A byte arriving on the expiry cycle takes priority over the timeout
        if (i_rx_done) begin
          rx_cnt_d = RX_LOAD;
          if (rx_asc == ASC_LBRACE) begin
            restart = 1'b1;
          end else begin
            case (state_q)
              ST_CMD: begin
                if (rx_asc == ASC_W) begin
                  is_read_d = 1'b0;
                  state_d   = ST_COLON;
                end else if (rx_asc == ASC_R) begin
                  is_read_d = 1'b1;
                  state_d   = ST_COLON;
                end else begin
                  err = 1'b1;
                end
              end
              ST_COLON: begin
                if (rx_asc == ASC_COLON) begin
                  dig_d   = 8'd0;
                  state_d = ST_ADDR;
                end else begin
                  err = 1'b1;
                end
              end
              ST_ADDR: begin
                if (rx_is_hex) begin
                  addr_d = (addr_q << 4) | SPI_ADDR_WIDTH'(rx_nib);
                  dig_d  = dig_q + 8'd1;
                  if (dig_q == ADDR_LAST) state_d = is_read_q ? ST_CLOSE : ST_EQ;
                end else begin
                  err = 1'b1;
                end
              end
              ST_EQ: begin
                if (rx_asc == ASC_EQ) begin
                  dig_d   = 8'd0;
                  state_d = ST_DATA;
                end else begin
                  err = 1'b1;
                end
              end
              ST_DATA: begin
                if (rx_is_hex) begin
                  wdata_d = (wdata_q << 4) | SPI_DATA_WIDTH'(rx_nib);
                  dig_d   = dig_q + 8'd1;
                  if (dig_q == DATA_LAST) state_d = ST_CLOSE;
                end else begin
                  err = 1'b1;
                end
              end
              ST_CLOSE: begin
                if (rx_asc == ASC_RBRACE) begin
                  spi_cnt_d = SPI_LOAD;
                  state_d   = ST_SPI_START;
                end else begin
                  err = 1'b1;
                end
              end
              default: err = 1'b1;
            endcase
          end
        end else if (RX_TIMEOUT != 0) begin
          if (rx_cnt_q <= 32'd1) err = 1'b1;
          else                   rx_cnt_d = rx_cnt_q - 32'd1;
        end
      end
      ST_SPI_START: begin
        state_d = ST_SPI_WAIT;
      end
      ST_SPI_WAIT: begin
        if (i_spi_done) begin
          rd_sh_d   = RD_W'(i_spi_rdata);
          reply_d   = is_read_q ? RPL_READ : RPL_OK;
          tx_idx_d  = 8'd0;
          tx_wait_d = 1'b0;
          state_d   = ST_TX;
        end else if (spi_cnt_q <= 32'd1) begin
          err = 1'b1;
        end else begin
          spi_cnt_d = spi_cnt_q - 32'd1;
        end
      end
      ST_TX: begin
        // Offer one byte, then hold off until uart_tx shows it took it
        if (!tx_wait_q) begin
          if (i_uart_idle && !data_valid_q) begin
            data_tx_d    = UART_DATA_WIDTH'(tx_char);
            data_valid_d = 1'b1;
            tx_wait_d    = 1'b1;
          end
        end else if (!i_uart_idle) begin
          tx_wait_d = 1'b0;
          if (tx_idx_q == tx_last) begin
            state_d = ST_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 8'd1;
            if (reply_q == RPL_READ) rd_sh_d = rd_sh_q << 4;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d  = ST_CMD;
      dig_d    = 8'd0;
      addr_d   = '0;
      wdata_d  = '0;
      rx_cnt_d = RX_LOAD;
    end

    if (err) begin
      state_d   = ST_TX;
      reply_d   = RPL_ERR;
      tx_idx_d  = 8'd0;
      tx_wait_d = 1'b0;
      rx_cnt_d  = 32'd0;
      spi_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      reply_q      <= RPL_OK;
      is_read_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dig_q        <= 8'd0;
      rx_cnt_q     <= 32'd0;
      spi_cnt_q    <= 32'd0;
      tx_idx_q     <= 8'd0;
      tx_wait_q    <= 1'b0;
      rd_sh_q      <= '0;
      data_tx_q    <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      reply_q      <= reply_d;
      is_read_q    <= is_read_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dig_q        <= dig_d;
      rx_cnt_q     <= rx_cnt_d;
      spi_cnt_q    <= spi_cnt_d;
      tx_idx_q     <= tx_idx_d;
      tx_wait_q    <= tx_wait_d;
      rd_sh_q      <= rd_sh_d;
      data_tx_q    <= data_tx_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign o_data_tx    = data_tx_q;
  assign o_data_valid = data_valid_q;
  assign o_spi_start  = (state_q == ST_SPI_START);
  assign o_spi_rw     = is_read_q;
  assign o_spi_addr   = addr_q;
  assign o_spi_wdata  = wdata_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_ld_debug   = led_code(state_q);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: scripted commands, a behavioural uart_tx
// that collects replies, and hand-computed expected SPI fields and replies.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  uart_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        uart_idle = 1'b1;
  logic [7:0]  data_tx;
  logic        data_valid;
  logic        spi_start;
  logic        spi_rw;
  logic [5:0]  spi_addr;
  logic [19:0] spi_wdata;
  logic        spi_done = 1'b0;
  logic [19:0] spi_rdata = 20'h0;
  logic        busy;
  logic [6:0]  ld_debug;

  int          compares = 0;
  int          fails = 0;
  int          spi_starts = 0;
  logic        cap_rw;
  logic [5:0]  cap_addr;
  logic [19:0] cap_wdata;
  string       reply = "";

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .SPI_ADDR_WIDTH  (6),
    .SPI_DATA_WIDTH  (20),
    .UART_DATA_WIDTH (8),
    .RX_TIMEOUT      (50),
    .SPI_TIMEOUT     (64)
  ) dut (
    .i_clk_sys    (clk),
    .i_rst_n      (rst_n),
    .i_uart_data  (uart_data),
    .i_rx_done    (rx_done),
    .i_uart_idle  (uart_idle),
    .o_data_tx    (data_tx),
    .o_data_valid (data_valid),
    .o_spi_start  (spi_start),
    .o_spi_rw     (spi_rw),
    .o_spi_addr   (spi_addr),
    .o_spi_wdata  (spi_wdata),
    .i_spi_done   (spi_done),
    .i_spi_rdata  (spi_rdata),
    .o_busy       (busy),
    .o_ld_debug   (ld_debug)
  );

  // uart_tx model: takes a strobed byte, then stays busy for three cycles
  initial begin
    forever begin
      @(negedge clk);
      if (data_valid) begin
        reply = $sformatf("%s%c", reply, data_tx);
        uart_idle = 1'b0;
        repeat (3) @(negedge clk);
        uart_idle = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (spi_start) begin
        spi_starts = spi_starts + 1;
        cap_rw    = spi_rw;
        cap_addr  = spi_addr;
        cap_wdata = spi_wdata;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares = compares + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reply(input string tag, input string exp);
    compares = compares + 1;
    assert (reply == exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed len %0d \"%s\" expected len %0d \"%s\"", tag, reply.len(), reply, exp.len(), exp);
    end
    reply = "";
  endtask

  task automatic send_byte(input logic [7:0] c);
    @(negedge clk);
    uart_data = c;
    rx_done   = 1'b1;
    @(negedge clk);
    rx_done   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_start(input int prev, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (spi_starts != prev) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic pulse_done(input logic [19:0] rd);
    repeat (3) @(negedge clk);
    spi_rdata = rd;
    spi_done  = 1'b1;
    @(negedge clk);
    spi_done  = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_led", 64'(ld_debug), 64'd0);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_start", 64'(spi_start), 64'd0);
    check("rst_addr", 64'(spi_addr), 64'd0);
    check("rst_data_tx", 64'(data_tx), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // plain write
    send_cmd("{W:2A=12345}");
    wait_start(0, "wr_start_seen");
    check("wr_starts", 64'(spi_starts), 64'd1);
    check("wr_rw", 64'(cap_rw), 64'd0);
    check("wr_addr", 64'(cap_addr), 64'h2A);
    check("wr_wdata", 64'(cap_wdata), 64'h12345);
    pulse_done(20'h0);
    wait_idle(200, "wr_idle");
    check_reply("wr_reply", "OK\n");

    // read, with a stray byte dropped while the SPI access is pending
    send_cmd("{R:05}");
    wait_start(1, "rd_start_seen");
    check("rd_rw", 64'(cap_rw), 64'd1);
    check("rd_addr", 64'(cap_addr), 64'h05);
    send_byte(8'h7B);
    check("rd_busy_stray", 64'(busy), 64'd1);
    pulse_done(20'h0BEEF);
    wait_idle(300, "rd_idle");
    check_reply("rd_reply", "0BEEF\n");
    check("rd_starts", 64'(spi_starts), 64'd2);

    // bad hex digit, then recovery
    send_cmd("{W:2G");
    wait_idle(200, "err_idle");
    check_reply("err_reply", "ERR\n");
    check("err_no_start", 64'(spi_starts), 64'd2);
    send_cmd("{R:01}");
    wait_start(2, "rec_start_seen");
    check("rec_addr", 64'(cap_addr), 64'h01);
    pulse_done(20'h00001);
    wait_idle(300, "rec_idle");
    check_reply("rec_reply", "00001\n");

    // resync on '{' mid-command, lowercase hex
    send_cmd("{W:1");
    send_cmd("{R:3f}");
    wait_start(3, "sync_start_seen");
    check("sync_starts", 64'(spi_starts), 64'd4);
    check("sync_rw", 64'(cap_rw), 64'd1);
    check("sync_addr", 64'(cap_addr), 64'h3F);
    pulse_done(20'hA5C3D);
    wait_idle(300, "sync_idle");
    check_reply("sync_reply", "A5C3D\n");

    // RX inactivity timeout (50 cycles)
    send_cmd("{R:0");
    repeat (40) @(negedge clk);
    check("rxto_early_busy", 64'(busy), 64'd1);
    check_reply("rxto_early_reply", "");
    wait_idle(200, "rxto_idle");
    check_reply("rxto_reply", "ERR\n");
    check("rxto_no_start", 64'(spi_starts), 64'd4);

    // SPI completion timeout (64 cycles), late done ignored
    send_cmd("{W:01=ABCDE}");
    wait_start(4, "spito_start_seen");
    check("spito_wdata", 64'(cap_wdata), 64'hABCDE);
    repeat (40) @(negedge clk);
    check("spito_early_busy", 64'(busy), 64'd1);
    wait_idle(300, "spito_idle");
    check_reply("spito_reply", "ERR\n");
    pulse_done(20'h12345);
    repeat (5) @(negedge clk);
    check("late_done_busy", 64'(busy), 64'd0);
    check_reply("late_done_reply", "");
    check("spito_starts", 64'(spi_starts), 64'd5);

    // reset during SPI_WAIT
    send_cmd("{R:12}");
    wait_start(5, "rstw_start_seen");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_addr", 64'(spi_addr), 64'd0);
    check("rstw_rw", 64'(spi_rw), 64'd0);
    check("rstw_led", 64'(ld_debug), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_reply("rstw_no_reply", "");
    check("rstw_starts", 64'(spi_starts), 64'd6);
    send_cmd("{W:3F=fffff}");
    wait_start(6, "post_start_seen");
    check("post_addr", 64'(cap_addr), 64'h3F);
    check("post_wdata", 64'(cap_wdata), 64'hFFFFF);
    pulse_done(20'h0);
    wait_idle(200, "post_idle");
    check_reply("post_reply", "OK\n");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
